// File: rtl/mem_stage.sv
// Memory stage: passes ALU/PC results through, or runs one data-memory access
// per instruction with a request/ack handshake and load extraction.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_valid,
  input  logic [31:0] EXE_ALU_out,
  input  logic [31:0] EXE_pc_to_reg,
  input  logic [31:0] EXE_rs2_data,
  input  logic [4:0]  EXE_rd_addr,
  input  logic [2:0]  EXE_funct3,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_RegWrite,
  input  logic        EXE_PCtoReg,
  output logic        MEM_stall,
  output logic        DM_req,
  output logic [3:0]  DM_we,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_wdata,
  input  logic [31:0] DM_rdata,
  input  logic        DM_ack,
  output logic        MEM_valid,
  output logic [31:0] MEM_rd_data,
  output logic [4:0]  MEM_rd_addr,
  output logic        MEM_RegWrite,
  output logic        MEM_err
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_next;

  logic       pend_load;
  logic       pend_regwrite;
  logic [4:0] pend_rd;
  logic [2:0] pend_funct3;
  logic [1:0] pend_lo;

  logic        accept;
  logic        is_mem;
  logic        illegal;
  logic        misaligned;
  logic        acc_err;
  logic [1:0]  lo;
  logic [3:0]  store_we;
  logic [31:0] store_wdata;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign lo        = EXE_ALU_out[1:0];
  assign accept    = EXE_valid && (state == IDLE);
  assign is_mem    = EXE_MemRead || EXE_MemWrite;
  assign MEM_stall = (state == WAIT);

  // Stores only have B/H/W encodings; loads additionally allow BU/HU.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (EXE_MemRead && EXE_MemWrite) illegal = 1'b1;
    case (EXE_funct3)
      3'b000:         misaligned = 1'b0;
      3'b001:         misaligned = lo[0];
      3'b010:         misaligned = (lo != 2'b00);
      3'b100:         illegal    = illegal || EXE_MemWrite;
      3'b101: begin
        illegal    = illegal || EXE_MemWrite;
        misaligned = lo[0];
      end
      default:        illegal    = 1'b1;
    endcase
  end

  assign acc_err = is_mem && (illegal || misaligned);

  always_comb begin
    store_we    = 4'b1111;
    store_wdata = EXE_rs2_data;
    case (EXE_funct3[1:0])
      2'b00: begin
        store_we    = 4'b0001 << lo;
        store_wdata = {4{EXE_rs2_data[7:0]}};
      end
      2'b01: begin
        store_we    = 4'b0011 << lo;
        store_wdata = {2{EXE_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = DM_rdata[8*pend_lo +: 8];
  assign ld_half = pend_lo[1] ? DM_rdata[31:16] : DM_rdata[15:0];

  always_comb begin
    case (pend_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = DM_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mem && !acc_err) state_next = WAIT;
      WAIT: if (DM_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; MEM_valid is cleared every cycle unless a result retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      DM_req        <= 1'b0;
      DM_we         <= 4'd0;
      DM_addr       <= 32'd0;
      DM_wdata      <= 32'd0;
      MEM_valid     <= 1'b0;
      MEM_rd_data   <= 32'd0;
      MEM_rd_addr   <= 5'd0;
      MEM_RegWrite  <= 1'b0;
      MEM_err       <= 1'b0;
      pend_load     <= 1'b0;
      pend_regwrite <= 1'b0;
      pend_rd       <= 5'd0;
      pend_funct3   <= 3'd0;
      pend_lo       <= 2'd0;
    end else begin
      MEM_valid <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          MEM_valid    <= 1'b1;
          MEM_rd_data  <= EXE_PCtoReg ? EXE_pc_to_reg : EXE_ALU_out;
          MEM_rd_addr  <= EXE_rd_addr;
          MEM_RegWrite <= EXE_RegWrite && (EXE_rd_addr != 5'd0);
          MEM_err      <= 1'b0;
        end else if (acc_err) begin
          MEM_valid    <= 1'b1;
          MEM_rd_data  <= 32'd0;
          MEM_rd_addr  <= EXE_rd_addr;
          MEM_RegWrite <= 1'b0;
          MEM_err      <= 1'b1;
        end else begin
          DM_req        <= 1'b1;
          DM_addr       <= {EXE_ALU_out[31:2], 2'b00};
          DM_we         <= EXE_MemWrite ? store_we : 4'b0000;
          DM_wdata      <= store_wdata;
          pend_load     <= EXE_MemRead;
          pend_regwrite <= EXE_RegWrite && (EXE_rd_addr != 5'd0);
          pend_rd       <= EXE_rd_addr;
          pend_funct3   <= EXE_funct3;
          pend_lo       <= lo;
        end
      end else if (state == WAIT && DM_ack) begin
        DM_req       <= 1'b0;
        MEM_valid    <= 1'b1;
        MEM_rd_addr  <= pend_rd;
        MEM_err      <= 1'b0;
        MEM_RegWrite <= pend_load && pend_regwrite;
        if (pend_load) MEM_rd_data <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through ops, loads/stores, errors, reset aborts.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_valid;
  logic [31:0] EXE_ALU_out, EXE_pc_to_reg, EXE_rs2_data;
  logic [4:0]  EXE_rd_addr;
  logic [2:0]  EXE_funct3;
  logic        EXE_MemRead, EXE_MemWrite, EXE_RegWrite, EXE_PCtoReg;
  logic        MEM_stall, DM_req;
  logic [3:0]  DM_we;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic        DM_ack;
  logic        MEM_valid;
  logic [31:0] MEM_rd_data;
  logic [4:0]  MEM_rd_addr;
  logic        MEM_RegWrite, MEM_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .EXE_valid(EXE_valid), .EXE_ALU_out(EXE_ALU_out),
    .EXE_pc_to_reg(EXE_pc_to_reg), .EXE_rs2_data(EXE_rs2_data), .EXE_rd_addr(EXE_rd_addr),
    .EXE_funct3(EXE_funct3), .EXE_MemRead(EXE_MemRead), .EXE_MemWrite(EXE_MemWrite),
    .EXE_RegWrite(EXE_RegWrite), .EXE_PCtoReg(EXE_PCtoReg), .MEM_stall(MEM_stall),
    .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
    .DM_rdata(DM_rdata), .DM_ack(DM_ack), .MEM_valid(MEM_valid), .MEM_rd_data(MEM_rd_data),
    .MEM_rd_addr(MEM_rd_addr), .MEM_RegWrite(MEM_RegWrite), .MEM_err(MEM_err)
  );

  task automatic clear_inputs();
    EXE_valid = 0; EXE_ALU_out = 0; EXE_pc_to_reg = 0; EXE_rs2_data = 0;
    EXE_rd_addr = 0; EXE_funct3 = 0; EXE_MemRead = 0; EXE_MemWrite = 0;
    EXE_RegWrite = 0; EXE_PCtoReg = 0; DM_rdata = 0; DM_ack = 0;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic [2:0] f3, input logic rd_en, input logic wr_en, input logic rw);
    clear_inputs();
    EXE_valid = 1; EXE_ALU_out = alu; EXE_rs2_data = rs2; EXE_rd_addr = rd;
    EXE_funct3 = f3; EXE_MemRead = rd_en; EXE_MemWrite = wr_en; EXE_RegWrite = rw;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({DM_req, DM_we, DM_addr, DM_wdata, MEM_valid, MEM_rd_data, MEM_rd_addr, MEM_RegWrite, MEM_err, MEM_stall} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h valid=%b rd_data=%h stall=%b, expected all zero",
               DM_req, DM_we, DM_addr, DM_wdata, MEM_valid, MEM_rd_data, MEM_stall);
    end
    rst = 0;
  endtask

  task automatic test_alu_op();
    issue(32'h0000_1234, 0, 5'd5, 3'b000, 0, 0, 1);
    @(negedge clk);
    checks++;
    if ({MEM_valid, MEM_RegWrite, DM_req, MEM_err} !== 4'b1100 || MEM_rd_data !== 32'h1234 || MEM_rd_addr !== 5'd5) begin
      errors++;
      $display("[TB] FAIL alu_op: valid=%b rw=%b req=%b err=%b data=%h rd=%0d, expected 1 1 0 0 00001234 5",
               MEM_valid, MEM_RegWrite, DM_req, MEM_err, MEM_rd_data, MEM_rd_addr);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (MEM_valid !== 1'b0 || MEM_rd_data !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL alu_pulse_hold: valid=%b data=%h, expected 0 00001234", MEM_valid, MEM_rd_data);
    end
  endtask

  task automatic test_pc_to_reg();
    issue(32'h0000_0001, 0, 5'd1, 3'b000, 0, 0, 1);
    EXE_PCtoReg = 1; EXE_pc_to_reg = 32'h0000_ABCD;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (MEM_valid !== 1'b1 || MEM_rd_data !== 32'h0000_ABCD || MEM_RegWrite !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pc_to_reg: valid=%b data=%h rw=%b, expected 1 0000abcd 1", MEM_valid, MEM_rd_data, MEM_RegWrite);
    end
  endtask

  task automatic test_load_byte();
    issue(32'h0000_0103, 0, 5'd7, 3'b000, 1, 0, 1);
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (MEM_stall !== 1'b1 || DM_req !== 1'b1 || DM_addr !== 32'h100 || DM_we !== 4'b0000 || MEM_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lb_wait%0d: stall=%b req=%b addr=%h we=%b valid=%b, expected 1 1 00000100 0000 0",
                 i, MEM_stall, DM_req, DM_addr, DM_we, MEM_valid);
      end
      if (i == 2) begin
        DM_ack = 1; DM_rdata = 32'h80AA_BBCC;
      end
      @(negedge clk);
    end
    DM_ack = 0;
    checks++;
    if (MEM_stall !== 1'b0 || DM_req !== 1'b0 || MEM_valid !== 1'b1 || MEM_rd_data !== 32'hFFFF_FF80 ||
        MEM_RegWrite !== 1'b1 || MEM_rd_addr !== 5'd7 || MEM_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lb_result: stall=%b req=%b valid=%b data=%h rw=%b rd=%0d err=%b, expected 0 0 1 ffffff80 1 7 0",
               MEM_stall, DM_req, MEM_valid, MEM_rd_data, MEM_RegWrite, MEM_rd_addr, MEM_err);
    end
  endtask

  task automatic test_store_half();
    issue(32'h0000_0202, 32'h1234_5678, 5'd3, 3'b001, 0, 1, 0);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (DM_req !== 1'b1 || DM_we !== 4'b1100 || DM_wdata !== 32'h5678_5678 || DM_addr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL sh_request: req=%b we=%b wdata=%h addr=%h, expected 1 1100 56785678 00000200",
               DM_req, DM_we, DM_wdata, DM_addr);
    end
    DM_ack = 1;
    @(negedge clk);
    DM_ack = 0;
    checks++;
    if (MEM_valid !== 1'b1 || MEM_RegWrite !== 1'b0 || DM_req !== 1'b0 || MEM_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sh_result: valid=%b rw=%b req=%b stall=%b, expected 1 0 0 0", MEM_valid, MEM_RegWrite, DM_req, MEM_stall);
    end
  endtask

  task automatic test_store_byte();
    issue(32'h0000_0001, 32'h0000_00A5, 5'd0, 3'b000, 0, 1, 0);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (DM_we !== 4'b0010 || DM_wdata !== 32'hA5A5_A5A5 || DM_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_request: we=%b wdata=%h req=%b, expected 0010 a5a5a5a5 1", DM_we, DM_wdata, DM_req);
    end
    DM_ack = 1;
    @(negedge clk);
    DM_ack = 0;
  endtask

  task automatic test_misaligned();
    issue(32'h0000_0101, 0, 5'd9, 3'b010, 1, 0, 1);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (DM_req !== 1'b0 || MEM_valid !== 1'b1 || MEM_err !== 1'b1 || MEM_RegWrite !== 1'b0 ||
        MEM_rd_data !== 32'd0 || MEM_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lw_misaligned: req=%b valid=%b err=%b rw=%b data=%h stall=%b, expected 0 1 1 0 00000000 0",
               DM_req, MEM_valid, MEM_err, MEM_RegWrite, MEM_rd_data, MEM_stall);
    end
    issue(32'h0000_0000, 0, 5'd4, 3'b010, 1, 1, 1);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (DM_req !== 1'b0 || MEM_valid !== 1'b1 || MEM_err !== 1'b1 || MEM_RegWrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_and_write: req=%b valid=%b err=%b rw=%b, expected 0 1 1 0", DM_req, MEM_valid, MEM_err, MEM_RegWrite);
    end
  endtask

  task automatic test_load_hu_rd0();
    issue(32'h0000_0002, 0, 5'd0, 3'b101, 1, 0, 1);
    @(negedge clk);
    clear_inputs();
    DM_ack = 1; DM_rdata = 32'hF00D_0000;
    @(negedge clk);
    DM_ack = 0;
    checks++;
    if (MEM_valid !== 1'b1 || MEM_rd_data !== 32'h0000_F00D || MEM_RegWrite !== 1'b0 || MEM_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lhu_rd0: valid=%b data=%h rw=%b err=%b, expected 1 0000f00d 0 0",
               MEM_valid, MEM_rd_data, MEM_RegWrite, MEM_err);
    end
  endtask

  task automatic test_ack_idle();
    clear_inputs();
    DM_ack = 1; DM_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    DM_ack = 0;
    checks++;
    if (MEM_valid !== 1'b0 || MEM_rd_data !== 32'h0000_F00D || MEM_stall !== 1'b0 || DM_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_idle: valid=%b data=%h stall=%b req=%b, expected 0 0000f00d 0 0",
               MEM_valid, MEM_rd_data, MEM_stall, DM_req);
    end
  endtask

  task automatic test_reset_in_wait();
    issue(32'h0000_0300, 0, 5'd2, 3'b010, 1, 0, 1);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (MEM_stall !== 1'b1 || DM_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_wait_enter: stall=%b req=%b, expected 1 1", MEM_stall, DM_req);
    end
    rst = 1; DM_ack = 1; DM_rdata = 32'h1111_1111;
    @(negedge clk);
    rst = 0;
    checks++;
    if (DM_req !== 1'b0 || MEM_stall !== 1'b0 || MEM_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_wait_abort: req=%b stall=%b valid=%b, expected 0 0 0", DM_req, MEM_stall, MEM_valid);
    end
    @(negedge clk);
    DM_ack = 0;
    checks++;
    if (DM_req !== 1'b0 || MEM_valid !== 1'b0 || MEM_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_late_ack: req=%b valid=%b stall=%b, expected 0 0 0", DM_req, MEM_valid, MEM_stall);
    end
    issue(32'h0000_0042, 0, 5'd6, 3'b000, 0, 0, 1);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (MEM_valid !== 1'b1 || MEM_rd_data !== 32'h42 || MEM_rd_addr !== 5'd6) begin
      errors++;
      $display("[TB] FAIL rst_then_accept: valid=%b data=%h rd=%0d, expected 1 00000042 6", MEM_valid, MEM_rd_data, MEM_rd_addr);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_alu_op();
    test_pc_to_reg();
    test_load_byte();
    test_store_half();
    test_store_byte();
    test_misaligned();
    test_load_hu_rd0();
    test_ack_idle();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
